// File: rtl/pipeline_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
// Signal bundle between the pipeline datapath and the hazard controller.
//   ID-stage info   : id_valid, id_rn/rm/rd, id_use_rn/rm/rd, id_rf_we, id_load
//   Branch qualifier: id_branch, cond_true
//   Memory status   : mem_req, mem_ready
//   Controls (back) : pc_ld, ifid_ld, pipe_en, id_nop, ifid_clear
//   Forwarding      : fwd_a (rn), fwd_b (rm), fwd_c (rd/store data)
//   Debug           : stall_state
// master = datapath side, slave = hazard controller.
// -----------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if;
   logic       id_valid;
   logic [3:0] id_rn;
   logic [3:0] id_rm;
   logic [3:0] id_rd;
   logic       id_use_rn;
   logic       id_use_rm;
   logic       id_use_rd;
   logic       id_rf_we;
   logic       id_load;
   logic       id_branch;
   logic       cond_true;
   logic       mem_req;
   logic       mem_ready;
   logic       pc_ld;
   logic       ifid_ld;
   logic       pipe_en;
   logic       id_nop;
   logic       ifid_clear;
   logic [1:0] fwd_a;
   logic [1:0] fwd_b;
   logic [1:0] fwd_c;
   logic [1:0] stall_state;

   modport master (
      output id_valid, id_rn, id_rm, id_rd, id_use_rn, id_use_rm, id_use_rd,
             id_rf_we, id_load, id_branch, cond_true, mem_req, mem_ready,
      input  pc_ld, ifid_ld, pipe_en, id_nop, ifid_clear,
             fwd_a, fwd_b, fwd_c, stall_state
   );

   modport slave (
      input  id_valid, id_rn, id_rm, id_rd, id_use_rn, id_use_rm, id_use_rd,
             id_rf_we, id_load, id_branch, cond_true, mem_req, mem_ready,
      output pc_ld, ifid_ld, pipe_en, id_nop, ifid_clear,
             fwd_a, fwd_b, fwd_c, stall_state
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Hazard unit for a 5-stage pipeline: operand forwarding, load-use bubble,
// data-memory wait freeze and taken-branch IF/ID flush.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : pipeline_hazard_ctrl_if.slave (ID info in, pipeline controls out)
// Shadow records mirror the destination info of EX, MEM and WB. All control
// outputs are combinational; the FSM state is informational (debug view of
// what the pipeline is doing in the current cycle).
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl (
   input  logic                         clk,
   input  logic                         rst_n,
   pipeline_hazard_ctrl_if.slave        bus
);

   typedef struct packed {
      logic       valid;
      logic [3:0] dest;
      logic       we;
      logic       load;
   } rec_t;

   typedef enum logic [1:0] {
      ST_RUN      = 2'b00,
      ST_LD_STALL = 2'b01,
      ST_MEM_WAIT = 2'b10
   } state_t;

   rec_t   r_ex, r_mem, r_wb;
   state_t r_state;
   state_t w_state_nxt;

   logic w_mem_wait;
   logic w_load_use;
   logic w_taken;
   logic w_pc_ld, w_ifid_ld, w_pipe_en, w_id_nop, w_ifid_clear;

   // A record supplies a value for src when it will write that register.
   function automatic logic hit(input rec_t r, input logic [3:0] src);
      return r.valid & r.we & (r.dest == src);
   endfunction

   // Youngest producer wins; r15 (PC) is never forwarded.
   function automatic logic [1:0] fwd_sel(input logic [3:0] src, input logic use_src,
                                          input rec_t ex, input rec_t mm, input rec_t wb);
      logic [1:0] sel;
      sel = 2'b00;
      if (use_src && (src != 4'd15)) begin
         if (hit(ex, src))      sel = 2'b01;
         else if (hit(mm, src)) sel = 2'b10;
         else if (hit(wb, src)) sel = 2'b11;
      end
      return sel;
   endfunction

   function automatic logic ld_src_hit(input logic [3:0] src, input logic use_src,
                                       input logic [3:0] ex_dest);
      return use_src & (src != 4'd15) & (ex_dest == src);
   endfunction

   assign w_mem_wait = r_mem.valid & bus.mem_req & ~bus.mem_ready;

   assign w_load_use = bus.id_valid & r_ex.valid & r_ex.load & r_ex.we &
                       (ld_src_hit(bus.id_rn, bus.id_use_rn, r_ex.dest) |
                        ld_src_hit(bus.id_rm, bus.id_use_rm, r_ex.dest) |
                        ld_src_hit(bus.id_rd, bus.id_use_rd, r_ex.dest));

   // Gated by rst_n so the flush output shows its idle value while reset is held.
   assign w_taken = bus.id_valid & bus.id_branch & bus.cond_true & rst_n;

   // Control priority: memory wait freezes everything, load-use inserts one
   // bubble and holds the front end, otherwise a taken branch flushes IF/ID.
   // NOTE: every always_comb output gets a default first so no path leaves a
   // signal unassigned, which would infer a latch.
   always_comb begin
      w_pc_ld      = 1'b1;
      w_ifid_ld    = 1'b1;
      w_pipe_en    = 1'b1;
      w_id_nop     = 1'b0;
      w_ifid_clear = 1'b0;
      if (w_mem_wait) begin
         w_pc_ld   = 1'b0;
         w_ifid_ld = 1'b0;
         w_pipe_en = 1'b0;
      end else if (w_load_use) begin
         w_pc_ld   = 1'b0;
         w_ifid_ld = 1'b0;
         w_id_nop  = 1'b1;
      end else begin
         w_ifid_clear = w_taken;
      end
   end

   always_comb begin
      w_state_nxt = ST_RUN;
      case (r_state)
         ST_RUN, ST_LD_STALL, ST_MEM_WAIT: begin
            if (w_mem_wait)      w_state_nxt = ST_MEM_WAIT;
            else if (w_load_use) w_state_nxt = ST_LD_STALL;
            else                 w_state_nxt = ST_RUN;
         end
         default: w_state_nxt = ST_RUN;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, giving a true shift WB<=MEM<=EX<=ID.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ex    <= '0;
         r_mem   <= '0;
         r_wb    <= '0;
         r_state <= ST_RUN;
      end else begin
         r_state <= w_state_nxt;
         if (w_pipe_en) begin
            r_wb        <= r_mem;
            r_mem       <= r_ex;
            r_ex.valid  <= bus.id_valid & ~w_id_nop;
            r_ex.dest   <= bus.id_rd;
            r_ex.we     <= bus.id_rf_we;
            r_ex.load   <= bus.id_load;
         end
      end
   end

   assign bus.pc_ld       = w_pc_ld;
   assign bus.ifid_ld     = w_ifid_ld;
   assign bus.pipe_en     = w_pipe_en;
   assign bus.id_nop      = w_id_nop;
   assign bus.ifid_clear  = w_ifid_clear;
   assign bus.fwd_a       = fwd_sel(bus.id_rn, bus.id_use_rn, r_ex, r_mem, r_wb);
   assign bus.fwd_b       = fwd_sel(bus.id_rm, bus.id_use_rm, r_ex, r_mem, r_wb);
   assign bus.fwd_c       = fwd_sel(bus.id_rd, bus.id_use_rd, r_ex, r_mem, r_wb);
   assign bus.stall_state = r_state;

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 id_valid  in  1  ID holds a live, condition-passed instruction.
REQ-005 id_rn, id_rm, id_rd  in  4 each  ID source/destination register numbers.
REQ-006 id_use_rn, id_use_rm, id_use_rd  in  1 each  marks the source as read (id_use_rd is the store data source).
REQ-007 id_rf_we  in  1  ID instruction writes id_rd (decoder RF-enable bit).
REQ-008 id_load  in  1  ID instruction is a load (decoder load bit).
REQ-009 id_branch, cond_true  in  1 each  taken-branch qualifiers from the decoder and condition unit.
REQ-010 mem_req, mem_ready  in  1 each  MEM-stage data-memory request and completion.
REQ-011 pc_ld, ifid_ld, pipe_en  out  1 each  PC load, IF/ID load, and ID/EX-EX/MEM-MEM/WB register enables.
REQ-012 id_nop  out  1  force a bubble into ID/EX.
REQ-013 ifid_clear  out  1  flush IF/ID.
REQ-014 fwd_a, fwd_b, fwd_c  out  2 each  operand select for rn/rm/rd: 00 = RF, 01 = EX, 10 = MEM, 11 = WB.
REQ-015 stall_state  out  2  FSM state for debug.

Function
REQ-016 Internal shadow records EX, MEM and WB each hold {valid, dest[3:0], we, load}.
REQ-017 When pipe_en=1, shadow records shift on the clock edge: WB<=MEM, MEM<=EX, EX<=ID fields.
REQ-018 EX.valid on shift = id_valid & ~id_nop; when pipe_en=0, all records hold.
REQ-019 Forwarding (combinational): a source selects the youngest matching stage, priority EX > MEM > WB.
REQ-020 A stage matches when valid & we & dest == source & use bit set; otherwise 00.
REQ-021 Register 15 is never forwarded (fwd=00).
REQ-022 Load-use hazard = id_valid & EX.valid & EX.load & EX.we & dest matches any used ID source (r15 excluded).
REQ-023 FSM states: RUN=00, LD_STALL=01, MEM_WAIT=10; 11 unreachable and recovers to RUN.
REQ-024 RUN -> MEM_WAIT when MEM.valid & mem_req & ~mem_ready; else RUN -> LD_STALL on load-use hazard.
REQ-025 LD_STALL -> RUN after exactly one cycle, unless the MEM_WAIT condition holds (then MEM_WAIT).
REQ-026 MEM_WAIT -> RUN in the cycle mem_ready=1; the pipeline advances on that same edge.
REQ-027 Outputs are combinational from current inputs and records; state is next-cycle only.
REQ-028 MEM-wait condition true (any state): pipe_en=0, pc_ld=0, ifid_ld=0, id_nop=0, ifid_clear=0.
REQ-029 Load-use hazard without MEM-wait: pipe_en=1, pc_ld=0, ifid_ld=0, id_nop=1, ifid_clear=0.
REQ-030 Taken branch (id_valid & id_branch & cond_true) with no stall: ifid_clear=1 for exactly that cycle; pc_ld=ifid_ld=pipe_en=1.
REQ-031 Priority: MEM-wait > load-use > branch flush; a suppressed branch stays in ID and flushes when it next issues.
REQ-032 A load-use hazard lasts at most one bubble: after the bubble the load sits in MEM, and forwarding 10 resolves it.
REQ-033 mem_ready high with no mem_req has no effect.
REQ-034 A MEM-wait of N cycles freezes the pipeline for exactly N cycles.

Reset
REQ-035 rst_n=0 asynchronously clears all records to valid=0 and sets state RUN.
REQ-036 Reset values: pc_ld=1, ifid_ld=1, pipe_en=1, id_nop=0, ifid_clear=0, fwd_*=00, stall_state=00.
REQ-037 Reset mid-stall or mid-wait abandons the stall immediately, with no residual bubble.

Verification
REQ-038 Forwarding: ADD r3 then SUB r4,r3,r3 back-to-back -> fwd_a=fwd_b=01 in SUB's ID cycle; no stall.
REQ-039 Load-use: LDR r2 then ADD r5,r2,r1 -> one cycle with pc_ld=0, ifid_ld=0, id_nop=1.
REQ-039 (cont.) Next cycle: fwd_a=10, state back to RUN.
REQ-040 Memory wait: store in MEM with mem_ready low for 3 cycles -> pipe_en=0 for exactly 3 cycles, state=10.
REQ-040 (cont.) Pipeline resumes on the mem_ready edge.
REQ-041 Branch: taken B in ID -> ifid_clear=1 for one cycle.
REQ-041 (cont.) With cond_true=0 -> ifid_clear=0.
REQ-041 (cont.) Branch coincident with a load-use hazard -> no flush until the stall clears.
REQ-042 Priority and reset: MEM-wait coinciding with load-use -> id_nop=0 and pipe_en=0.
REQ-042 (cont.) rst_n pulsed low during MEM_WAIT -> state 00 and all outputs at reset values with no clock edge.
REQ-043 r15 and WB: write to r15 followed by a reader -> fwd=00.
REQ-043 (cont.) Producer three instructions ahead -> fwd=11.
